sort_seq: RTL and testbench
===========================

Name: sort_seq

Overview:
- Bubble-sort sequencer for a buffer of DEPTH unsigned n-bit words.
- Shares one n-bit magnitude comparator across all element pairs.
- Three phases: load words over a valid/ready stream, sort in place with one compare/swap per clock, stream the result out.
- Sits between a producer and consumer in the sort datapath.

Parameters:
n, 8, data word width in bits
DEPTH, 8, number of elements per sort job (>= 2)
ASCEND, 1, 1 = ascending order, 0 = descending order

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a job; sampled only in IDLE
in_valid  input  1  in_data valid
in_data  input  n  element being loaded
in_ready  output  1  high in LOAD only
out_valid  output  1  high in UNLOAD only
out_data  output  n  current output element
out_ready  input  1  consumer accepts out_data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last output transfer

Behaviour:
- Reset: one clock; reset is asynchronous and active-low; rst_n low asynchronously forces the following, also mid-job (the job is abandoned, no done):
  - state IDLE, all buffer entries 0, all counters 0
  - in_ready, out_valid, busy, done = 0; out_data = 0
- IDLE -> LOAD on start=1. start is ignored in every other state.
- LOAD:
  - Each cycle with in_valid & in_ready, write in_data to buf[ld_idx] and increment ld_idx.
  - After the DEPTH-th transfer -> SORT on the next edge; in_ready drops the same edge.
  - in_valid outside LOAD is ignored.
- SORT:
  - Registers: pair index i (from 0), pass limit lim (from DEPTH-1), swapped flag.
  - Each cycle compare buf[i] vs buf[i+1] through the single comparator.
  - Swap both entries on the same edge when out of order: gt if ASCEND=1, lt if ASCEND=0.
  - Equal elements never swap, so the sort is stable.
  - When i == lim-1, end of pass:
    - If no swap occurred this pass (including this cycle), or lim == 1 -> UNLOAD.
    - Otherwise lim <= lim-1, i <= 0, swapped <= 0.
  - Cycle counts: already-sorted input takes DEPTH-1 SORT cycles; worst case takes DEPTH*(DEPTH-1)/2 (28 for DEPTH=8).
- UNLOAD:
  - out_valid=1, out_data=buf[ul_idx].
  - On out_valid & out_ready, increment ul_idx.
  - out_data is stable while out_ready is low.
  - After the DEPTH-th transfer -> IDLE with done=1 for exactly that one cycle.
- Widths:
  - Indices are clog2(DEPTH) bits.
  - Counters compare against DEPTH-1 and never wrap past it.
  - Comparison is unsigned, full n bits.
- Buffer contents persist after done until the next load overwrites them.

Decomposition:
- Shared package:
  - state encoding constants: IDLE, LOAD, SORT, UNLOAD
  - clog2-based index-width helper
- Sub-module: instantiate the team's existing n-bit comparator comp_nb once, with parameter n passed through.
  - Its eq/lt/gt drive the swap decision; no other compare logic exists in the block.

Test Plan:
1. n=8, DEPTH=4, ASCEND=1: load 3,1,4,2; out_ready=1 -> out 1,2,3,4; done one cycle after the 4th transfer; busy high from the cycle after start until done.
2. Already sorted 5,6,7,8 -> exactly 3 SORT cycles, no swaps, out 5,6,7,8. Reverse 8,7,6,5 -> exactly 6 SORT cycles, out 5,6,7,8.
3. Duplicates and extremes 255,0,255,0 -> out 0,0,255,255. ASCEND=0 with 3,1,4,2 -> out 4,3,2,1.
4. Backpressure:
   - Toggle in_valid randomly during LOAD; load must capture exactly 4 words in order.
   - Hold out_ready low 5 cycles mid-UNLOAD; out_data holds its value and no element is skipped or repeated.
5. Reset and spurious inputs:
   - Assert rst_n low during SORT: all outputs 0 immediately; no done.
   - A new job afterwards sorts correctly.
   - Pulse start during UNLOAD: it is ignored and the output sequence is unchanged.

Source files
------------

// File: rtl/sort_seq_pkg.sv
// +--------------------------------------------------------------------+
// | sort_seq_pkg : state encoding and index-width helper for sort_seq  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package sort_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SORT   = 2'd2,
    UNLOAD = 2'd3
  } state_e;

  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/comp_nb.sv
// +--------------------------------------------------------------------+
// | comp_nb : unsigned n-bit magnitude comparator                      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module comp_nb #(
  parameter int n = 8
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  output logic         eq_o,
  output logic         lt_o,
  output logic         gt_o
);

  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);
  assign gt_o = (a_i >  b_i);

endmodule

`default_nettype wire

// File: rtl/sort_seq.sv
// +--------------------------------------------------------------------+
// | sort_seq : load / bubble-sort / unload sequencer, one cmp per clk  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sort_seq
  import sort_seq_pkg::*;
#(
  parameter int n      = 8,
  parameter int DEPTH  = 8,
  parameter int ASCEND = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [n-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [n-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int             IW   = idx_w(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  state_e         state_q;
  logic [n-1:0]   mem_q [DEPTH];
  logic [IW-1:0]  ld_idx_q;
  logic [IW-1:0]  ul_idx_q;
  logic [IW-1:0]  i_q;
  logic [IW-1:0]  lim_q;
  logic           swapped_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           done_q;

  logic [IW-1:0]  i_nxt;
  logic [n-1:0]   elem_a;
  logic [n-1:0]   elem_b;
  logic           cmp_eq;
  logic           cmp_lt;
  logic           cmp_gt;
  logic           do_swap;

  assign i_nxt  = i_q + 1'b1;
  assign elem_a = mem_q[i_q];
  assign elem_b = mem_q[i_nxt];

  comp_nb #(.n(n)) u_comp (
    .a_i  (elem_a),
    .b_i  (elem_b),
    .eq_o (cmp_eq),
    .lt_o (cmp_lt),
    .gt_o (cmp_gt)
  );

  // Equal pairs never swap, which keeps the sort stable.
  assign do_swap = !cmp_eq && ((ASCEND != 0) ? cmp_gt : cmp_lt);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? mem_q[ul_idx_q] : '0;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      ld_idx_q    <= '0;
      ul_idx_q    <= '0;
      i_q         <= '0;
      lim_q       <= '0;
      swapped_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            ld_idx_q   <= '0;
          end
        end
        LOAD: begin
          if (in_valid && in_ready_q) begin
            mem_q[ld_idx_q] <= in_data;
            if (ld_idx_q == LAST) begin
              ld_idx_q   <= '0;
              in_ready_q <= 1'b0;
              state_q    <= SORT;
              i_q        <= '0;
              lim_q      <= LAST;
              swapped_q  <= 1'b0;
            end else begin
              ld_idx_q <= ld_idx_q + 1'b1;
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            mem_q[i_q]   <= elem_b;
            mem_q[i_nxt] <= elem_a;
          end
          if (i_q == lim_q - 1'b1) begin
            // A clean pass means everything below lim is already ordered.
            if (!(swapped_q || do_swap) || (lim_q == IW'(1))) begin
              state_q     <= UNLOAD;
              out_valid_q <= 1'b1;
              ul_idx_q    <= '0;
            end else begin
              lim_q     <= lim_q - 1'b1;
              i_q       <= '0;
              swapped_q <= 1'b0;
            end
          end else begin
            i_q       <= i_nxt;
            swapped_q <= swapped_q || do_swap;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (ul_idx_q == LAST) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              ul_idx_q    <= '0;
            end else begin
              ul_idx_q <= ul_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sort_seq.sv
// +--------------------------------------------------------------------+
// | tb_sort_seq : directed self-checking bench for sort_seq (DEPTH=4)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sort_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_d = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       sel = 1'b0;

  logic       in_ready_a, out_valid_a, busy_a, done_a;
  logic       in_ready_d, out_valid_d, busy_d, done_d;
  logic [7:0] out_data_a, out_data_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sort_seq #(.n(8), .DEPTH(4), .ASCEND(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
    .busy(busy_a), .done(done_a)
  );

  sort_seq #(.n(8), .DEPTH(4), .ASCEND(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .out_data(out_data_d), .out_ready(out_ready),
    .busy(busy_d), .done(done_d)
  );

  // Observe whichever instance the current test is driving.
  logic       o_rdy, o_valid, o_busy, o_done;
  logic [7:0] o_data;
  assign o_rdy   = sel ? in_ready_d  : in_ready_a;
  assign o_valid = sel ? out_valid_d : out_valid_a;
  assign o_busy  = sel ? busy_d      : busy_a;
  assign o_done  = sel ? done_d      : done_a;
  assign o_data  = sel ? out_data_d  : out_data_a;

  task automatic set_start(input logic v);
    if (sel) start_d = v; else start_a = v;
  endtask

  task automatic load_words(input logic [31:0] words, input bit toggle,
                            output logic busy_seen, output bit ok);
    int  k;
    int  cyc;
    bit  v;
    bit  fire;
    @(posedge clk); #1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    k = 0; cyc = 0; busy_seen = 1'b0;
    while (k < 4 && cyc < 60) begin
      v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? words[31-8*k -: 8] : 8'($urandom);
      @(negedge clk);
      if (cyc == 0) busy_seen = o_busy;
      fire = v && o_rdy;
      @(posedge clk); #1;
      if (fire) k++;
      cyc++;
    end
    in_valid = 1'b0;
    ok = (k == 4);
  endtask

  task automatic count_sort(output int cnt, output bit ok);
    cnt = 0; ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_valid) begin
        ok = 1;
        break;
      end
      if (o_busy && !o_rdy) cnt++;
    end
  endtask

  // Entered at the negedge of the first UNLOAD cycle.
  task automatic collect(input int stall_at, input int stall_len, input bit pulse_start,
                         output logic [31:0] got, output bit hold_ok, output bit early_done,
                         output logic done_at, output logic busy_at, output logic done_after,
                         output bit ok);
    int         k;
    int         cyc;
    int         stall_cnt;
    bit         have_held;
    logic [7:0] held;
    k = 0; cyc = 0; stall_cnt = 0; have_held = 0; held = 8'h00;
    got = 32'h0; hold_ok = 1; early_done = 0;
    while (k < 4 && cyc < 100) begin
      if (o_done) early_done = 1;
      if (!out_ready) begin
        if (!have_held) begin
          held = o_data;
          have_held = 1;
        end else if (o_data !== held) begin
          hold_ok = 0;
        end
      end
      if (o_valid && out_ready) begin
        got[31-8*k -: 8] = o_data;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
      set_start(pulse_start && cyc == 1);
      if (stall_at > 0 && k == stall_at && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (k < 4) @(negedge clk);
    end
    set_start(1'b0);
    out_ready = 1'b1;
    ok = (k == 4);
    @(negedge clk);
    done_at = o_done;
    busy_at = o_busy;
    @(negedge clk);
    done_after = o_done;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready_a, out_valid_a, busy_a, done_a, out_data_a} !== 12'h000) begin
      fails++;
      $display("FAIL reset_a: got %b %b %b %b %h, want all 0",
               in_ready_a, out_valid_a, busy_a, done_a, out_data_a);
    end
    tests++;
    if ({in_ready_d, out_valid_d, busy_d, done_d, out_data_d} !== 12'h000) begin
      fails++;
      $display("FAIL reset_d: got %b %b %b %b %h, want all 0",
               in_ready_d, out_valid_d, busy_d, done_d, out_data_d);
    end
    rst_n = 1'b1;
  endtask

  // Runs one job end to end and checks the sorted stream and done timing.
  task automatic test_job(input string name, input logic s, input logic [31:0] words,
                          input logic [31:0] expect_out, input int expect_cycles,
                          input bit toggle, input int stall_at, input bit pulse_start);
    logic        busy_seen, done_at, busy_at, done_after;
    logic [31:0] got;
    bit          ok_l, ok_s, ok_c, hold_ok, early;
    int          cnt;
    sel = s;
    load_words(words, toggle, busy_seen, ok_l);
    tests++;
    if (!ok_l || busy_seen !== 1'b1) begin
      fails++;
      $display("FAIL %s_load: loaded_all=%0d busy=%b, want 1 1", name, ok_l, busy_seen);
    end
    count_sort(cnt, ok_s);
    tests++;
    if (!ok_s || (expect_cycles >= 0 && cnt != expect_cycles)) begin
      fails++;
      $display("FAIL %s_sort_cycles: reached_unload=%0d cycles=%0d, want 1 %0d",
               name, ok_s, cnt, expect_cycles);
    end
    collect(stall_at, 5, pulse_start, got, hold_ok, early, done_at, busy_at, done_after, ok_c);
    tests++;
    if (!ok_c || got !== expect_out) begin
      fails++;
      $display("FAIL %s_out: got %h (complete=%0d), want %h", name, got, ok_c, expect_out);
    end
    tests++;
    if (early || done_at !== 1'b1 || busy_at !== 1'b0 || done_after !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: early=%0d done=%b busy=%b next_done=%b, want 0 1 0 0",
               name, early, done_at, busy_at, done_after);
    end
    if (stall_at > 0) begin
      tests++;
      if (!hold_ok) begin
        fails++;
        $display("FAIL %s_hold: out_data changed while stalled, want stable", name);
      end
    end
  endtask

  task automatic test_reset_mid_sort;
    logic busy_seen;
    bit   ok_l;
    bit   saw_done;
    sel = 1'b0;
    load_words(32'h08070605, 1'b0, busy_seen, ok_l);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready_a, out_valid_a, busy_a, done_a, out_data_a} !== 12'h000) begin
      fails++;
      $display("FAIL mid_reset: got %b %b %b %b %h, want all 0",
               in_ready_a, out_valid_a, busy_a, done_a, out_data_a);
    end
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_a) saw_done = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_a || busy_a) saw_done = 1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL mid_reset_no_done: done/busy seen=%0d, want 0", saw_done);
    end
  endtask

  task automatic test_start_in_unload;
    test_job("start_unload", 1'b0, 32'h03010402, 32'h01020304, -1, 1'b0, 0, 1'b1);
    @(negedge clk);
    tests++;
    if (busy_a !== 1'b0) begin
      fails++;
      $display("FAIL start_unload_idle: busy=%b, want 0", busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_job("basic",   1'b0, 32'h03010402, 32'h01020304, -1, 1'b0, 0, 1'b0);
    test_job("sorted",  1'b0, 32'h05060708, 32'h05060708,  3, 1'b0, 0, 1'b0);
    test_job("reverse", 1'b0, 32'h08070605, 32'h05060708,  6, 1'b0, 0, 1'b0);
    test_job("dups",    1'b0, 32'hFF00FF00, 32'h0000FFFF, -1, 1'b0, 0, 1'b0);
    test_job("descend", 1'b1, 32'h03010402, 32'h04030201, -1, 1'b0, 0, 1'b0);
    test_job("backpr",  1'b0, 32'h09020704, 32'h02040709, -1, 1'b1, 2, 1'b0);
    test_reset_mid_sort();
    test_job("after_rst", 1'b0, 32'h03010402, 32'h01020304, -1, 1'b0, 0, 1'b0);
    test_start_in_unload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
